// File: rtl/addr_gen.sv
// Address-generation stage: drives the registered external address bus and sequences
// indexed fix-up, forced dummy and pointer-pair cycles. Optional: ADDR_GEN_JMP_PAGE_BUG_EN.
module addr_gen #(
  parameter int unsigned AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          start,
  input  logic [2:0]    mode,
  input  logic          force_fix,
  input  logic [AW-1:0] pc,
  input  logic [7:0]    sp,
  input  logic [AW-1:0] base,
  input  logic [7:0]    index,
  output logic [AW-1:0] addr,
  output logic          addr_valid,
  output logic          page_cross,
  output logic          busy,
  output logic          done
);

  if (AW != 16) begin : g_aw_check
    $error("addr_gen: only AW == 16 is supported");
  end

  typedef enum logic [1:0] {StIdle, StFirst, StFinal} state_e;

  localparam logic [2:0] ModePc    = 3'd0;
  localparam logic [2:0] ModeStack = 3'd1;
  localparam logic [2:0] ModeZp    = 3'd2;
  localparam logic [2:0] ModeZpx   = 3'd3;
  localparam logic [2:0] ModeAbs   = 3'd4;
  localparam logic [2:0] ModeAbsx  = 3'd5;
  localparam logic [2:0] ModeInd   = 3'd6;
  localparam logic [2:0] ModeZpind = 3'd7;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          valid_q, valid_d;
  logic          page_cross_q, page_cross_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [2:0]    mode_q, mode_d;
  logic [AW-1:0] base_q, base_d;
  logic [7:0]    index_q, index_d;

  logic [8:0]    lo_sum;
  logic [7:0]    ptr_lo_inc;
  logic          two_cycle;

  assign lo_sum     = {1'b0, base[7:0]} + {1'b0, index};
  assign ptr_lo_inc = base_q[7:0] + 8'd1;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    valid_d      = valid_q;
    page_cross_d = page_cross_q;
    busy_d       = busy_q;
    done_d       = done_q;
    mode_d       = mode_q;
    base_d       = base_q;
    index_d      = index_q;
    two_cycle    = 1'b0;

    if (rdy) begin
      if (start && !busy_q) begin
        mode_d       = mode;
        base_d       = base;
        index_d      = index;
        valid_d      = 1'b1;
        page_cross_d = 1'b0;
        unique case (mode)
          ModePc:    addr_d = pc;
          ModeStack: addr_d = {8'h01, sp};
          ModeZp:    addr_d = {8'h00, base[7:0]};
          ModeZpx:   addr_d = {8'h00, lo_sum[7:0]};
          ModeAbs:   addr_d = base;
          ModeAbsx: begin
            if (lo_sum[8] || force_fix) begin
              // Dummy read at the un-carried address; the high byte is fixed next cycle.
              two_cycle    = 1'b1;
              addr_d       = {base[AW-1:8], lo_sum[7:0]};
              page_cross_d = lo_sum[8];
            end else begin
              addr_d = base + {{(AW-8){1'b0}}, index};
            end
          end
          ModeInd: begin
            two_cycle = 1'b1;
            addr_d    = base;
          end
          ModeZpind: begin
            two_cycle = 1'b1;
            addr_d    = {8'h00, base[7:0]};
          end
          default: addr_d = pc;
        endcase
        state_d = two_cycle ? StFirst : StFinal;
        busy_d  = two_cycle;
        done_d  = !two_cycle;
      end else if (state_q == StFirst) begin
        state_d      = StFinal;
        valid_d      = 1'b1;
        page_cross_d = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b1;
        case (mode_q)
`ifdef ADDR_GEN_JMP_PAGE_BUG_EN
          ModeInd:   addr_d = {base_q[AW-1:8], ptr_lo_inc};
`else
          ModeInd:   addr_d = base_q + {{(AW-1){1'b0}}, 1'b1};
`endif
          ModeZpind: addr_d = {8'h00, ptr_lo_inc};
          default:   addr_d = base_q + {{(AW-8){1'b0}}, index_q};
        endcase
      end else begin
        // Idle: address bus keeps its last value.
        state_d      = StIdle;
        valid_d      = 1'b0;
        page_cross_d = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      valid_q      <= 1'b0;
      page_cross_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mode_q       <= '0;
      base_q       <= '0;
      index_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      valid_q      <= valid_d;
      page_cross_q <= page_cross_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      mode_q       <= mode_d;
      base_q       <= base_d;
      index_q      <= index_d;
    end
  end

  assign addr       = addr_q;
  assign addr_valid = valid_q;
  assign page_cross = page_cross_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_addr_gen.sv
// Bench for addr_gen: directed vector table, reset/stall/back-to-back sequences, and
// random transactions checked against an arithmetic reference model.
module tb_addr_gen;

  logic        clk = 1'b0;
  logic        rst, rdy, start, force_fix;
  logic [2:0]  mode;
  logic [15:0] pc, base, addr;
  logic [7:0]  sp, index;
  logic        addr_valid, page_cross, busy, done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  addr_gen #(.AW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .start      (start),
    .mode       (mode),
    .force_fix  (force_fix),
    .pc         (pc),
    .sp         (sp),
    .base       (base),
    .index      (index),
    .addr       (addr),
    .addr_valid (addr_valid),
    .page_cross (page_cross),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    string       name;
    logic [2:0]  mode;
    logic [15:0] base;
    logic [7:0]  index;
    logic        ff;
    logic [15:0] pc;
    logic [7:0]  sp;
    int          n;
    logic [15:0] a0;
    logic        pc0;
    logic [15:0] a1;
  } vec_t;

`ifdef ADDR_GEN_JMP_PAGE_BUG_EN
  localparam bit JmpBug = 1'b1;
`else
  localparam bit JmpBug = 1'b0;
`endif

  function automatic vec_t mk(string name, logic [2:0] m, logic [15:0] b, logic [7:0] x,
                              logic ff, logic [15:0] p, logic [7:0] s, int n,
                              logic [15:0] a0, logic pc0, logic [15:0] a1);
    vec_t v;
    v.name = name; v.mode = m; v.base = b; v.index = x; v.ff = ff; v.pc = p; v.sp = s;
    v.n = n; v.a0 = a0; v.pc0 = pc0; v.a1 = a1;
    return v;
  endfunction

  // Reference model from the addressing rules, in plain integer arithmetic.
  function automatic vec_t model(logic [2:0] m, logic [15:0] b, logic [7:0] x, logic ff,
                                 logic [15:0] p, logic [7:0] s);
    int bi = int'(b);
    int xi = int'(x);
    int lo = (bi % 256) + xi;
    int n = 1, a0 = 0, a1 = 0;
    bit pcx = 1'b0;
    case (m)
      3'd0: a0 = int'(p);
      3'd1: a0 = 256 + int'(s);
      3'd2: a0 = bi % 256;
      3'd3: a0 = lo % 256;
      3'd4: a0 = bi;
      3'd5: begin
        if (lo >= 256 || ff) begin
          n = 2; a0 = (bi / 256) * 256 + lo % 256; pcx = (lo >= 256); a1 = (bi + xi) % 65536;
        end else a0 = bi + xi;
      end
      3'd6: begin
        n = 2; a0 = bi;
        a1 = JmpBug ? (bi / 256) * 256 + (bi % 256 + 1) % 256 : (bi + 1) % 65536;
      end
      default: begin n = 2; a0 = bi % 256; a1 = (bi % 256 + 1) % 256; end
    endcase
    return mk("rand", m, b, x, ff, p, s, n, a0[15:0], pcx, a1[15:0]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    mode = v.mode; base = v.base; index = v.index; force_fix = v.ff; pc = v.pc; sp = v.sp;
  endtask

  // Issue one transaction and check every cycle through the idle cycle after it.
  task automatic run_vec(input vec_t v);
    logic [15:0] last;
    drive(v);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({v.name, " c1 addr"}, addr, v.a0);
    chk({v.name, " c1 valid"}, addr_valid, 1);
    chk({v.name, " c1 pcross"}, page_cross, v.pc0);
    chk({v.name, " c1 done"}, done, v.n == 1);
    chk({v.name, " c1 busy"}, busy, v.n == 2);
    last = v.a0;
    if (v.n == 2) begin
      tick();
      chk({v.name, " c2 addr"}, addr, v.a1);
      chk({v.name, " c2 done"}, done, 1);
      chk({v.name, " c2 busy"}, busy, 0);
      chk({v.name, " c2 pcross"}, page_cross, 0);
      last = v.a1;
    end
    tick();
    chk({v.name, " idle valid"}, addr_valid, 0);
    chk({v.name, " idle done"}, done, 0);
    chk({v.name, " idle addr hold"}, addr, last);
  endtask

  vec_t vecs[11];

  initial begin
    rst = 1'b1; rdy = 1'b1; start = 1'b0; mode = '0; force_fix = 1'b0;
    pc = '0; sp = '0; base = '0; index = '0;

    vecs[0]  = mk("pc",        3'd0, 16'h0000, 8'h00, 0, 16'hC000, 8'h00, 1, 16'hC000, 0, 16'h0);
    vecs[1]  = mk("absx_cross", 3'd5, 16'h12F0, 8'h20, 0, 16'h0, 8'h0, 2, 16'h1210, 1, 16'h1310);
    vecs[2]  = mk("absx_nc",   3'd5, 16'h1200, 8'h05, 0, 16'h0, 8'h0, 1, 16'h1205, 0, 16'h0);
    vecs[3]  = mk("absx_force", 3'd5, 16'h1200, 8'h05, 1, 16'h0, 8'h0, 2, 16'h1205, 0, 16'h1205);
    vecs[4]  = mk("zpx_wrap",  3'd3, 16'hABF0, 8'h20, 0, 16'h0, 8'h0, 1, 16'h0010, 0, 16'h0);
    vecs[5]  = mk("stack",     3'd1, 16'h0000, 8'h00, 0, 16'h0, 8'hFD, 1, 16'h01FD, 0, 16'h0);
    vecs[6]  = mk("zpind_wrap", 3'd7, 16'h34FF, 8'h00, 0, 16'h0, 8'h0, 2, 16'h00FF, 0, 16'h0000);
    vecs[7]  = mk("absx_ffff", 3'd5, 16'hFFFF, 8'h01, 0, 16'h0, 8'h0, 2, 16'hFF00, 1, 16'h0000);
    vecs[8]  = mk("ind",       3'd6, 16'h10FF, 8'h00, 0, 16'h0, 8'h0, 2, 16'h10FF, 0,
                  JmpBug ? 16'h1000 : 16'h1100);
    vecs[9]  = mk("zp",        3'd2, 16'h5678, 8'h00, 0, 16'h0, 8'h0, 1, 16'h0078, 0, 16'h0);
    vecs[10] = mk("abs",       3'd4, 16'h4016, 8'h00, 0, 16'h0, 8'h0, 1, 16'h4016, 0, 16'h0);

    // Reset values.
    tick();
    chk("rst addr", addr, 16'h0000);
    chk("rst valid", addr_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset mid-FIRST aborts immediately.
    drive(vecs[1]);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("abort pre addr", addr, 16'h1210);
    rst = 1'b1;
    #1;
    chk("abort addr", addr, 16'h0000);
    chk("abort valid", addr_valid, 0);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort pcross", page_cross, 0);
    tick();
    rst = 1'b0;
    run_vec(vecs[0]);

    // Stall during FIRST, start ignored while busy, then back-to-back start in FINAL.
    drive(vecs[1]);
    start = 1'b1;
    tick();
    start = 1'b0;
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      mode = 3'd4; base = 16'h4016;
      tick();
      chk("stall addr", addr, 16'h1210);
      chk("stall done", done, 0);
      chk("stall busy", busy, 1);
      chk("stall pcross", page_cross, 1);
    end
    rdy = 1'b1;
    tick();
    chk("resume addr", addr, 16'h1310);
    chk("resume done", done, 1);
    tick();
    start = 1'b0;
    chk("b2b addr", addr, 16'h4016);
    chk("b2b done", done, 1);
    chk("b2b valid", addr_valid, 1);
    tick();
    chk("b2b idle valid", addr_valid, 0);

    // Random transactions against the model.
    for (int i = 0; i < 150; i++) begin
      run_vec(model(3'($urandom_range(0, 7)), 16'($urandom), 8'($urandom),
                    1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
